step3_normalize_round: RTL and testbench

- Downstream consumer of the FP MAC adder stage.
- Takes the adder's unnormalized magnitude sum, plus the delayed operand signs and current (larger, biased) exponent from the adder status delay line.
- Produces a packed IEEE-754 single-precision result: normalize, round-to-nearest-even, overflow/underflow handling.
- 3-stage pipeline with valid/ready handshake and global stall.

---
 rtl/step3_normalize_round_if.sv | 26 ++
 rtl/step3_normalize_round.sv | 115 +++++++++++
 tb/tb_step3_normalize_round.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/step3_normalize_round_if.sv
// step3_normalize_round_if: adder-side beat and packed-result handshake for the normalize/round stage
interface step3_normalize_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign_in1;
  logic                   in_sign_in2;
  logic [EXP_W-1:0]       in_current_ex;
  logic [MAN_W+3:0]       in_mant;
  logic                   in_mag_neg;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W-1:0] out_result;
  logic                   out_overflow;
  logic                   out_underflow;
  modport master (
    output in_valid, in_sign_in1, in_sign_in2, in_current_ex, in_mant, in_mag_neg, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );
  modport slave (
    input  in_valid, in_sign_in1, in_sign_in2, in_current_ex, in_mant, in_mag_neg, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/step3_normalize_round.sv
// step3_normalize_round: 3-stage normalize + round-to-nearest-even packer for the FP MAC adder output
module step3_normalize_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic                  clock,
  input  logic                  resetn,
  step3_normalize_round_if.slave bus
);
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(MW);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EMIN = '0;

  logic stall;
  assign stall = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  logic          zero_c, sign_c;
  logic [LW-1:0] lzc_c;
  assign zero_c = bus.in_mant == '0;
  assign sign_c = (bus.in_sign_in1 == bus.in_sign_in2) ? bus.in_sign_in1 :
                  zero_c ? 1'b0 : bus.in_sign_in1 ^ bus.in_mag_neg;
  always_comb begin
    lzc_c = LW'(MAN_W + 3);
    for (int i = 0; i < MAN_W + 3; i++) if (bus.in_mant[i]) lzc_c = LW'(MAN_W + 2 - i);
  end

  logic             v1, sign1, zero1, inf1;
  logic [LW-1:0]    lzc1;
  logic [MW-1:0]    mant1;
  logic [EXP_W-1:0] ex1;

  // Carry: one right shift folding the lost bit into sticky; otherwise left shift by lzc.
  logic                    carry1;
  logic [MW-2:0]           lsh;
  logic [MAN_W-1:0]        sig_c;
  logic                    g_c, r_c, s_c;
  logic signed [XW-1:0]    exp_c;
  assign carry1 = mant1[MW-1];
  assign lsh    = mant1[MW-2:0] << lzc1;
  assign sig_c  = carry1 ? mant1[MW-1:4] : lsh[MW-2:3];
  assign g_c    = carry1 ? mant1[3] : lsh[2];
  assign r_c    = carry1 ? mant1[2] : lsh[1];
  assign s_c    = carry1 ? |mant1[1:0] : lsh[0];
  assign exp_c  = carry1 ? {2'b00, ex1} + XW'(1) : {2'b00, ex1} - {{(XW-LW){1'b0}}, lzc1};

  logic                 v2, sign2, zero2, inf2, g2, r2, s2;
  logic [MAN_W-1:0]     sig2;
  logic signed [XW-1:0] exp2;

  // Rounding overflow of an all-ones significand leaves fraction zero and bumps the exponent.
  logic                     inc;
  logic [MAN_W:0]           sum;
  logic signed [XW-1:0]     exp_f;
  logic [MAN_W-2:0]         frac;
  logic                     ovf_c, unf_c;
  logic [EXP_W+MAN_W-1:0]   res_c;
  assign inc   = g2 & (r2 | s2 | sig2[0]);
  assign sum   = {1'b0, sig2} + {{MAN_W{1'b0}}, inc};
  assign exp_f = exp2 + {{(XW-1){1'b0}}, sum[MAN_W]};
  assign frac  = sum[MAN_W] ? '0 : sum[MAN_W-2:0];
  assign ovf_c = ~inf2 & ~zero2 & (exp_f >= EMAX);
  assign unf_c = ~inf2 & ~zero2 & (exp_f <= EMIN);
  assign res_c = (inf2 | ovf_c)  ? {sign2, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}} :
                 (zero2 | unf_c) ? {sign2, {(EXP_W+MAN_W-1){1'b0}}} :
                                   {sign2, exp_f[EXP_W-1:0], frac};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1                <= 1'b0;
      sign1             <= 1'b0;
      zero1             <= 1'b0;
      inf1              <= 1'b0;
      lzc1              <= '0;
      mant1             <= '0;
      ex1               <= '0;
      v2                <= 1'b0;
      sign2             <= 1'b0;
      zero2             <= 1'b0;
      inf2              <= 1'b0;
      g2                <= 1'b0;
      r2                <= 1'b0;
      s2                <= 1'b0;
      sig2              <= '0;
      exp2              <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_result    <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
    end else if (!stall) begin
      v1                <= bus.in_valid;
      sign1             <= sign_c;
      zero1             <= zero_c;
      inf1              <= &bus.in_current_ex;
      lzc1              <= lzc_c;
      mant1             <= bus.in_mant;
      ex1               <= bus.in_current_ex;
      v2                <= v1;
      sign2             <= sign1;
      zero2             <= zero1;
      inf2              <= inf1;
      g2                <= g_c;
      r2                <= r_c;
      s2                <= s_c;
      sig2              <= sig_c;
      exp2              <= exp_c;
      bus.out_valid     <= v2;
      bus.out_result    <= res_c;
      bus.out_overflow  <= ovf_c;
      bus.out_underflow <= unf_c;
    end
  end
endmodule

// File: tb/tb_step3_normalize_round.sv
// tb_step3_normalize_round: scoreboard bench for the normalize/round stage with an exact-remainder RNE model
module tb_step3_normalize_round;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] sbq[$];
  logic [33:0] sb_exp;

  step3_normalize_round_if bus ();
  step3_normalize_round dut (.clock(clock), .resetn(resetn), .bus(bus));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact model: locate the top set bit, keep 24 bits, round on the full discarded remainder.
  function automatic logic [33:0] model(input logic a, input logic b, input logic mn,
                                        input logic [7:0] ex, input logic [27:0] m);
    int p, e;
    logic [27:0] sig, rem, half;
    logic sg;
    sg = (a == b) ? a : ((m == 0) ? 1'b0 : a ^ mn);
    if (ex == 8'hFF) return {2'b00, sg, 8'hFF, 23'h0};
    if (m == 0) return {2'b00, sg, 31'h0};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    e = int'(ex) + p - 26;
    if (p > 23) begin
      sig  = m >> (p - 23);
      rem  = m & ((28'h1 << (p - 23)) - 28'h1);
      half = 28'h1 << (p - 24);
      if (rem > half || (rem == half && sig[0])) sig = sig + 28'h1;
    end else sig = m << (23 - p);
    if (sig[24]) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, sg, 31'h0};
    return {2'b00, sg, e[7:0], sig[22:0]};
  endfunction

  always @(negedge clock) if (resetn) begin
    if (bus.out_valid && bus.out_ready) begin
      check("out_has_beat", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        sb_exp = sbq.pop_front();
        check("result", 64'({bus.out_overflow, bus.out_underflow, bus.out_result}), 64'(sb_exp));
      end
    end
    if (bus.in_valid && bus.in_ready)
      sbq.push_back(model(bus.in_sign_in1, bus.in_sign_in2, bus.in_mag_neg, bus.in_current_ex, bus.in_mant));
  end

  task automatic send(input logic a, input logic b, input logic mn, input logic [7:0] ex, input logic [27:0] m);
    int t = 0;
    bus.in_valid      = 1'b1;
    bus.in_sign_in1   = a;
    bus.in_sign_in2   = b;
    bus.in_mag_neg    = mn;
    bus.in_current_ex = ex;
    bus.in_mant       = m;
    @(negedge clock);
    while (!bus.in_ready && t < 50) begin
      t++;
      @(negedge clock);
    end
    if (t >= 50) check("accept_timeout", 64'(t), 64'(49));
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("drain_empty", 64'(sbq.size()), 64'(0));
    @(posedge clock);
    #1;
  endtask

  task automatic latency(input string tag, input logic [31:0] exp);
    @(negedge clock);
    check({tag, "_c1"}, 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check({tag, "_c2"}, 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check({tag, "_c3"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_res"}, 64'(bus.out_result), 64'(exp));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.in_sign_in1 = 1'b0;
    bus.in_sign_in2 = 1'b0;
    bus.in_mag_neg = 1'b0;
    bus.in_current_ex = '0;
    bus.in_mant = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.out_result), 64'(0));
    check("rst_flags", 64'({bus.out_overflow, bus.out_underflow}), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    resetn = 1'b1;
    @(posedge clock);
    #1;
    send(1'b0, 1'b0, 1'b0, 8'd127, 28'h8000000);
    bus.in_valid = 1'b0;
    latency("one_plus_one", 32'h40000000);
    send(1'b0, 1'b1, 1'b0, 8'd127, 28'h1000000);
    send(1'b0, 1'b1, 1'b1, 8'd127, 28'h1000000);
    send(1'b0, 1'b0, 1'b0, 8'd127, 28'h7FFFFFC);
    send(1'b0, 1'b0, 1'b0, 8'd127, 28'h7FFFFF4);
    send(1'b0, 1'b1, 1'b0, 8'd127, 28'h0);
    send(1'b1, 1'b1, 1'b0, 8'd127, 28'h0);
    send(1'b0, 1'b0, 1'b0, 8'd254, 28'h8000000);
    send(1'b1, 1'b1, 1'b0, 8'd1, 28'h2000000);
    send(1'b1, 1'b0, 1'b0, 8'd255, 28'h0400000);
    send(1'b0, 1'b0, 1'b0, 8'd1, 28'h4000000);
    send(1'b0, 1'b0, 1'b0, 8'd200, 28'h0000001);
    bus.in_valid = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    fork
      begin
        send(1'b0, 1'b0, 1'b0, 8'd130, 28'h5A5A5A5);
        send(1'b1, 1'b1, 1'b0, 8'd100, 28'h8FFFFFF);
        send(1'b0, 1'b1, 1'b1, 8'd60, 28'h0003F0F);
        send(1'b1, 1'b0, 1'b0, 8'd200, 28'h7FFFFFE);
        bus.in_valid = 1'b0;
      end
      begin
        t = 0;
        @(negedge clock);
        while (!bus.out_valid && t < 20) begin
          t++;
          @(negedge clock);
        end
        if (t >= 20) check("bp_valid_timeout", 64'(t), 64'(19));
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clock);
          check("bp_in_ready", 64'(bus.in_ready), 64'(0));
          check("bp_hold", 64'(bus.out_valid), 64'(1));
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          check("bp_stream", 64'(bus.out_valid), 64'(1));
        end
      end
    join
    drain();
    fork
      for (int i = 0; i < 40; i++)
        send(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 255)),
             28'($urandom) >> $urandom_range(0, 27));
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clock);
          #1;
          bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 8'd127, 28'h8000000);
    send(1'b0, 1'b1, 1'b0, 8'd127, 28'h1000000);
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    resetn = 1'b0;
    #1;
    check("rst_async_valid", 64'(bus.out_valid), 64'(0));
    check("rst_async_result", 64'(bus.out_result), 64'(0));
    sbq.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_hold_valid", 64'(bus.out_valid), 64'(0));
    resetn = 1'b1;
    @(posedge clock);
    #1;
    send(1'b1, 1'b1, 1'b0, 8'd130, 28'h8000000);
    bus.in_valid = 1'b0;
    latency("post_rst", 32'hC1800000);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
